oumux_sched: RTL and testbench
==============================

// Module: oumux_sched
// PURPOSE
//  Scheduler for the output mux. Shares one upstream data stream among NK kernel destinations.
//  Arbitrates kernel requests round-robin and grants one kernel for a burst of up to BURST beats.
//  Drives the mux select and per-kernel valid strobes, and backpressures upstream.
//  Sits between the datapath output stage and oumux_dat_* instances.
// PARAMETERS
//  NK       4    number of kernel destinations (2..16)
//  SLICES   4    slices per beat
//  DW       16   bits per slice; beat width = SLICES*DW
//  SELW     2    select width, = clog2(NK)
//  BURST    8    max beats per grant (1..256)
//  TIMEOUT  64   stall cycles before abort (only with OUMUX_SCHED_WATCHDOG_EN)
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high
//  t_dat      in   SLICES*DW  upstream beat
//  t_valid    in   1          upstream beat valid
//  t_ready    out  1          upstream accept; = k_rdy[grant] in XFER, else 0
//  k_req      in   NK         kernel requests a burst (level)
//  k_rdy      in   NK         kernel can accept a beat this cycle
//  i_dat      out  SLICES*DW  beat to kernels; combinational copy of t_dat
//  i_valid    out  NK         one-hot beat strobe = onehot(grant) & {NK{t_valid & t_ready}}
//  sel        out  SELW       registered grant index to oumux_dat_*
//  busy       out  1          1 in ARB/XFER/GAP
//  to_flag    out  1          one-cycle pulse on watchdog abort (macro only; tied 0 otherwise)
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, t_ready=0, i_valid=0, busy=0, beat count=0, rr pointer=NK-1 (k0 first).
//  States: IDLE -> ARB -> XFER -> GAP -> IDLE.
//  IDLE: if |k_req, go to ARB; else stay. sel holds last value.
//  ARB (1 cycle): pick first set k_req at or after (ptr+1) mod NK, wrapping. Register grant into sel.
//   Set ptr=grant and count=0, then go to XFER. If k_req has dropped to 0, return to IDLE and leave ptr unchanged.
//  Grant latency: first beat can transfer 2 cycles after k_req rises in IDLE.
//  XFER: t_ready = k_rdy[sel]. A beat occurs when t_valid & t_ready. Each beat increments count (8-bit, no wrap past BURST).
//   Exit to GAP at end of the cycle in which the beat with count==BURST-1 occurs.
//   Exit to GAP if k_req[sel] deasserts; that cycle's beat, if any, still completes.
//   If both exit conditions hold in the same cycle: a single transition to GAP.
//   Stalls (t_valid=0 or k_rdy=0) hold state indefinitely without the macro.
//  GAP (1 cycle): t_ready=0, i_valid=0; turnaround so sel never changes while a beat is live. Then go to IDLE.
//  sel changes only on the ARB->XFER edge; i_valid is never asserted for a non-granted kernel.
//  A synchronous reset mid-burst drops the burst with no flush; the partial beat is not acknowledged.
// CONFIGURATION
//  OUMUX_SCHED_WATCHDOG_EN defined:
//   In XFER, a counter increments on each cycle with no beat and clears on a beat.
//   When it reaches TIMEOUT-1: go to GAP and pulse to_flag for 1 cycle. ptr stays at the grant, so the next grant goes elsewhere.
//  Macro undefined: no stall counter; to_flag is tied 0; XFER waits forever.
// STRUCTURE
//  oumux_pkg: state enum (IDLE, ARB, XFER, GAP); function clog2; default localparams for NK, SELW, BURST.
//  Sub-module oumux_rr_arb: combinational round-robin pick. Inputs: req[NK], ptr[SELW]. Outputs: gnt_idx[SELW], gnt_any.
//  Top holds the FSM, beat counter, watchdog and strobe generation.
// TESTING
//  1. k_req=0001, t_valid=1, k_rdy=1111 -> sel=0; 8 beats on i_valid=0001; GAP; IDLE; busy low after 11 cycles.
//  2. k_req=1111 held -> grants in order k0,k1,k2,k3,k0; each grant exactly 8 beats; sel stable within each burst.
//  3. Grant k2, then k_req[2] drops after beat 3 -> 3 beats delivered; GAP; next grant goes to k3.
//  4. Grant k1, k_rdy[1]=0 for 5 cycles mid-burst -> t_ready=0 and i_valid=0 during the stall; 8 beats total, none lost.
//  5. Reset asserted at beat 4 of a burst -> next cycle: all outputs at reset values; after release, k0 has first priority.
//  6. With the macro, TIMEOUT=64 and t_valid=0 in XFER -> to_flag pulses on stall cycle 64; GAP; next grant skips the stalled kernel.

Source files
------------

// File: rtl/oumux_pkg.sv
// Shared types and defaults for the output-mux scheduler.
// Holds the scheduler state enum, a constant-friendly clog2 and the
// default sizing used by oumux_sched and oumux_rr_arb.
package oumux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int DEF_NK    = 4;
  localparam int DEF_SELW  = clog2(DEF_NK);
  localparam int DEF_BURST = 8;

endpackage

// File: rtl/oumux_rr_arb.sv
// Combinational round-robin pick for the output-mux scheduler.
// Searches req starting one past ptr and wrapping, so the kernel granted
// last time has the lowest priority on the next pick.
module oumux_rr_arb
  import oumux_pkg::*;
#(
  parameter int NK   = DEF_NK,
  parameter int SELW = DEF_SELW
) (
  input  logic [NK-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  // First requester at or after ptr+1 (mod NK) wins
  always_comb begin
    logic [SELW-1:0] idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NK; i++) begin
      idx = SELW'((int'(ptr) + 1 + i) % NK);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/oumux_sched.sv
// Output-mux scheduler: shares one upstream beat stream among NK kernels.
// Kernels are granted round-robin for bursts of up to BURST beats; the
// select only moves on the ARB->XFER edge and a GAP cycle follows every
// burst so sel never changes while a beat is in flight.
// Optional stall watchdog: define OUMUX_SCHED_WATCHDOG_EN to abort a burst
// after TIMEOUT beat-less cycles and pulse to_flag.
module oumux_sched
  import oumux_pkg::*;
#(
  parameter int NK      = DEF_NK,
  parameter int SLICES  = 4,
  parameter int DW      = 16,
  parameter int SELW    = DEF_SELW,
`ifdef OUMUX_SCHED_WATCHDOG_EN
  parameter int TIMEOUT = 64,
`endif
  parameter int BURST   = DEF_BURST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SLICES*DW-1:0] t_dat,
  input  logic                 t_valid,
  output logic                 t_ready,
  input  logic [NK-1:0]        k_req,
  input  logic [NK-1:0]        k_rdy,
  output logic [SLICES*DW-1:0] i_dat,
  output logic [NK-1:0]        i_valid,
  output logic [SELW-1:0]      sel,
  output logic                 busy,
  output logic                 to_flag
);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [7:0]      count;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_any;
  logic            beat;
  logic            wd_fire;

  oumux_rr_arb #(
    .NK   (NK),
    .SELW (SELW)
  ) u_arb (
    .req     (k_req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Reset gates t_ready so a beat caught by a mid-burst reset is never acknowledged
  assign t_ready = (state == XFER) && k_rdy[sel] && !reset;
  assign beat    = t_valid && t_ready;
  assign busy    = (state != IDLE);
  assign i_dat   = t_dat;

  // Beat strobe only ever reaches the granted kernel
  always_comb begin
    i_valid      = '0;
    i_valid[sel] = beat;
  end

`ifdef OUMUX_SCHED_WATCHDOG_EN
  localparam int WDW = clog2(TIMEOUT) + 1;
  logic [WDW-1:0] stall_cnt;

  assign wd_fire = (state == XFER) && !beat && (stall_cnt == WDW'(TIMEOUT - 1));

  // Count consecutive beat-less XFER cycles and flag the abort for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      to_flag   <= 1'b0;
    end else begin
      to_flag <= wd_fire;
      if ((state != XFER) || beat) begin
        stall_cnt <= '0;
      end else if (!wd_fire) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign to_flag = 1'b0;
`endif

  // Scheduler FSM: arbitration, burst counting and the turnaround gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= SELW'(NK - 1);
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|k_req) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (gnt_any) begin
            sel   <= gnt_idx;
            ptr   <= gnt_idx;
            count <= '0;
            state <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (beat && (count != 8'(BURST - 1))) begin
            count <= count + 8'd1;
          end
          if ((beat && (count == 8'(BURST - 1))) || !k_req[sel] || wd_fire) begin
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oumux_sched.sv
// Self-checking bench for oumux_sched: a transaction-level model of who
// owns the mux, how many beats it has taken and whether a turnaround is
// pending is compared against the DUT every cycle, plus directed bursts
// with hand-worked expectations and a long randomized run.
module tb_oumux_sched;

  localparam int NK      = 4;
  localparam int SLICES  = 4;
  localparam int DW      = 16;
  localparam int SELW    = 2;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [SLICES*DW-1:0] t_dat;
  logic                 t_valid;
  logic                 t_ready;
  logic [NK-1:0]        k_req;
  logic [NK-1:0]        k_rdy;
  logic [SLICES*DW-1:0] i_dat;
  logic [NK-1:0]        i_valid;
  logic [SELW-1:0]      sel;
  logic                 busy;
  logic                 to_flag;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: current owner (-1 none), pending arbitration/turnaround
  bit modelValid = 0;
  int owner      = -1;
  bit arbPending = 0;
  bit gapPending = 0;
  int beatsTaken = 0;
  int lastGrant  = NK - 1;
  int selModel   = 0;
  int stalls     = 0;
  bit flagModel  = 0;
  int grantLog[$];

  // Observations of the DUT used by the directed scenarios
  int dutBeats[NK];
  bit busySeen;
  int readySeen;
  int flagCount;

  oumux_sched dut (
    .clk     (clk),
    .reset   (reset),
    .t_dat   (t_dat),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .k_req   (k_req),
    .k_rdy   (k_rdy),
    .i_dat   (i_dat),
    .i_valid (i_valid),
    .sel     (sel),
    .busy    (busy),
    .to_flag (to_flag)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [NK-1:0] req,
                               input logic [NK-1:0] rdy, input bit tv);
    reset   = rst;
    k_req   = req;
    k_rdy   = rdy;
    t_valid = tv;
    t_dat   = {$urandom, $urandom};
  endtask

  // Compare every DUT output with what the model says this cycle must show
  task automatic checkOutput();
    bit            expReady;
    logic [NK-1:0] expValid;
    if (!modelValid) return;
    expReady = !reset && (owner >= 0) && k_rdy[owner];
    expValid = '0;
    if (expReady && t_valid) expValid[owner] = 1'b1;
    checkVal("t_ready", t_ready, expReady);
    checkVal("i_valid", i_valid, expValid);
    checkVal("sel", sel, selModel);
    checkVal("busy", busy, arbPending || gapPending || (owner >= 0));
    checkVal("i_dat", i_dat, t_dat);
    checkVal("to_flag", to_flag, flagModel);
    for (int k = 0; k < NK; k++) begin
      if (i_valid[k] === 1'b1) dutBeats[k]++;
    end
    busySeen  = busy;
    readySeen += (t_ready === 1'b1) ? 1 : 0;
    flagCount += (to_flag === 1'b1) ? 1 : 0;
  endtask

  // Advance the model across the coming clock edge
  task automatic modelUpdate();
    bit beat;
    bit done;
    if (reset) begin
      modelValid = 1;
      owner      = -1;
      arbPending = 0;
      gapPending = 0;
      beatsTaken = 0;
      lastGrant  = NK - 1;
      selModel   = 0;
      stalls     = 0;
      flagModel  = 0;
      return;
    end
    if (!modelValid) return;
    flagModel = 0;
    if (gapPending) begin
      gapPending = 0;
    end else if (owner >= 0) begin
      beat = t_valid && k_rdy[owner];
      done = !k_req[owner];
      if (beat) begin
        beatsTaken++;
        stalls = 0;
        if (beatsTaken == BURST) done = 1;
      end
`ifdef OUMUX_SCHED_WATCHDOG_EN
      else if (stalls == TIMEOUT - 1) begin
        flagModel = 1;
        done      = 1;
      end else begin
        stalls++;
      end
`endif
      if (done) begin
        owner      = -1;
        gapPending = 1;
      end
    end else if (arbPending) begin
      arbPending = 0;
      for (int i = 0; i < NK; i++) begin
        int w;
        w = (lastGrant + 1 + i) % NK;
        if (owner < 0 && k_req[w]) begin
          owner      = w;
          selModel   = w;
          lastGrant  = w;
          beatsTaken = 0;
          stalls     = 0;
          grantLog.push_back(w);
        end
      end
    end else if (|k_req) begin
      arbPending = 1;
    end
  endtask

  task automatic stepCycle(input bit rst, input logic [NK-1:0] req,
                           input logic [NK-1:0] rdy, input bit tv);
    applyStimulus(rst, req, rdy, tv);
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    stepCycle(1'b1, '0, '0, 1'b0);
    stepCycle(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < NK; k++) dutBeats[k] = 0;
    grantLog.delete();
    readySeen = 0;
    flagCount = 0;
  endtask

  initial begin
    bit            busyAt10;
    int            total;
    logic [NK-1:0] req;
    reset   = 1'b1;
    k_req   = '0;
    k_rdy   = '0;
    t_valid = 1'b0;
    t_dat   = '0;
    @(posedge clk);
    #1;

    // Reset values
    doReset();
    checkVal("reset_sel", sel, 0);
    checkVal("reset_busy", busy, 0);
    checkVal("reset_t_ready", t_ready, 0);
    checkVal("reset_i_valid", i_valid, 0);

    // Single requester k0: 8 beats, idle again 11 cycles after the request
    busyAt10 = 0;
    for (int c = 0; c < 12; c++) begin
      stepCycle(1'b0, 4'b0001, 4'b1111, 1'b1);
      if (c == 10) busyAt10 = busySeen;
    end
    checkVal("s1_busy_c10", busyAt10, 1);
    checkVal("s1_busy_c11", busySeen, 0);
    checkVal("s1_beats_k0", dutBeats[0], 8);

    // All requesting: grants k0,k1,k2,k3,k0 with 8 beats each
    doReset();
    for (int c = 0; c < 44; c++) stepCycle(1'b0, 4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < NK; k++) checkVal($sformatf("s2_beats_k%0d", k), dutBeats[k], 8);
    for (int c = 0; c < 3; c++) stepCycle(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkVal("s2_grant_count", grantLog.size(), 5);
    for (int i = 0; i < grantLog.size() && i < 5; i++)
      checkVal($sformatf("s2_grant%0d", i), grantLog[i], i % NK);

    // k2 drops its request after 3 beats; k3 is next even though k0 also asks
    doReset();
    for (int c = 0; c < 5; c++) stepCycle(1'b0, 4'b0100, 4'b1111, 1'b1);
    for (int c = 5; c < 9; c++) stepCycle(1'b0, 4'b1001, 4'b1111, 1'b0);
    checkVal("s3_beats_k2", dutBeats[2], 3);
    checkVal("s3_grant_count", grantLog.size(), 2);
    if (grantLog.size() == 2) checkVal("s3_next_grant", grantLog[1], 3);

    // k1 stalls for 5 cycles mid-burst; no strobes while stalled, no beats lost
    doReset();
    for (int c = 0; c < 4; c++) stepCycle(1'b0, 4'b0010, 4'b1111, 1'b1);
    readySeen = 0;
    for (int c = 4; c < 9; c++) stepCycle(1'b0, 4'b0010, 4'b1101, 1'b1);
    checkVal("s4_ready_in_stall", readySeen, 0);
    checkVal("s4_beats_before_stall", dutBeats[1], 2);
    for (int c = 9; c < 15; c++) stepCycle(1'b0, 4'b0010, 4'b1111, 1'b1);
    for (int c = 15; c < 17; c++) stepCycle(1'b0, 4'b0000, 4'b1111, 1'b1);
    checkVal("s4_beats_k1", dutBeats[1], 8);

    // Reset on beat 4 of a k2 burst: beat 4 dropped, k0 first afterwards
    doReset();
    for (int c = 0; c < 5; c++) stepCycle(1'b0, 4'b0100, 4'b1111, 1'b1);
    stepCycle(1'b1, 4'b0100, 4'b1111, 1'b1);
    checkVal("s5_sel_after_reset", sel, 0);
    checkVal("s5_busy_after_reset", busy, 0);
    checkVal("s5_beats_k2", dutBeats[2], 3);
    grantLog.delete();
    for (int c = 0; c < 3; c++) stepCycle(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkVal("s5_first_grant_count", grantLog.size(), 1);
    if (grantLog.size() >= 1) checkVal("s5_first_grant", grantLog[0], 0);

`ifdef OUMUX_SCHED_WATCHDOG_EN
    // Stalled k0 is aborted after TIMEOUT idle cycles; k1 gets the next grant
    doReset();
    for (int c = 0; c < 66; c++) stepCycle(1'b0, 4'b0001, 4'b1111, 1'b0);
    for (int c = 66; c < 71; c++) stepCycle(1'b0, 4'b0011, 4'b1111, 1'b0);
    checkVal("s6_flag_pulses", flagCount, 1);
    checkVal("s6_grant_count", grantLog.size(), 2);
    if (grantLog.size() == 2) checkVal("s6_next_grant", grantLog[1], 1);
`endif

    // Randomized traffic with sticky requests and occasional resets
    doReset();
    req = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(15) == 0) req[k] = ~req[k];
      end
      stepCycle($urandom_range(499) == 0, req, NK'($urandom | $urandom),
                $urandom_range(3) != 0);
    end
    total = 0;
    for (int k = 0; k < NK; k++) total += dutBeats[k];
    checkVal("rand_activity", total > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
